// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: bundle of request/response and data-memory signals for lsu_ctrl.
//
// Signals
//   req_valid/req_ready       request handshake (accepted when both high)
//   req_we, req_funct3        store flag and RISC-V funct3 width/sign code
//   req_addr, req_wdata       byte address and right-aligned store data
//   resp_valid/data/err       one-cycle completion strobe with load data / error
//   MemRead, MemWrite         data-memory strobes
//   add, write_data           word-aligned memory address and full write word
//   read_data                 combinational memory read data
//
// Modports
//   slave  : the load/store controller
//   master : the environment (execute stage plus data memory)
interface lsu_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_data;
  logic              resp_err;
  logic              MemRead;
  logic              MemWrite;
  logic [ADDR_W-1:0] add;
  logic [31:0]       write_data;
  logic [31:0]       read_data;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, read_data,
    output req_ready, resp_valid, resp_data, resp_err,
           MemRead, MemWrite, add, write_data
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, read_data,
    input  req_ready, resp_valid, resp_data, resp_err,
           MemRead, MemWrite, add, write_data
  );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store controller between the execute stage and a
// word-addressed, combinational data memory. One request at a time.
// Byte/halfword stores are done as read-modify-write; loads are extracted
// and sign/zero-extended, returned on a one-cycle resp_valid strobe.
//
// Ports
//   clk    rising-edge clock
//   reset  synchronous, active-high; returns the FSM to IDLE, no response
//   bus    lsu_ctrl_if.slave (request, response and memory signals)
//
// Build option
//   LSU_MISALIGN_TRAP_EN  when defined, misaligned halfword/word accesses
//                         complete with resp_err=1 and no memory access;
//                         when undefined they are aligned down and proceed.
module lsu_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic      clk,
  input  logic      reset,
  lsu_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    WR     = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4,
    RESP   = 3'd5
  } state_t;

  state_t            state, state_nxt;

  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic [31:0]       resp_hold_q;
  logic              err_hold_q;

  logic              accept;
  logic              req_err;
  logic              mem_act;
  logic [31:0]       resp_now;

  // Load extraction: lane select by byte offset, then sign or zero extension.
  function automatic logic [31:0] load_ext(input logic [31:0] w,
                                           input logic [2:0]  f3,
                                           input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'h0, b};
      3'b101:  r = {16'h0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Sub-word store merge: replace the addressed byte or halfword lane.
  function automatic logic [31:0] lane_merge(input logic [31:0] w,
                                             input logic [2:0]  f3,
                                             input logic [1:0]  off,
                                             input logic [31:0] d);
    logic [31:0] r;
    r = w;
    if (f3[1:0] == 2'b00) r[{off, 3'b000} +: 8] = d[7:0];
    else                  r[{off[1], 4'b0000} +: 16] = d[15:0];
    return r;
  endfunction

  assign bus.req_ready = (state == IDLE);
  assign accept        = bus.req_valid & bus.req_ready;

  // Request legality, decided at acceptance so errors skip the memory.
  always_comb begin
    req_err = 1'b0;
    if (bus.req_we) begin
      req_err = (bus.req_funct3 >= 3'b011);
    end else begin
      req_err = (bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) ||
                (bus.req_funct3 == 3'b111);
    end
`ifdef LSU_MISALIGN_TRAP_EN
    case (bus.req_funct3[1:0])
      2'b01:   if (bus.req_addr[0])            req_err = 1'b1;
      2'b10:   if (bus.req_addr[1:0] != 2'b00) req_err = 1'b1;
      default: ;
    endcase
`endif
  end

  // ---- stage boundary: request capture on acceptance, read data capture ----
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= bus.req_we;
      f3_q    <= bus.req_funct3;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
      err_q   <= req_err;
    end
    if (bus.MemRead) rdata_q <= bus.read_data;
  end

  // ---- stage boundary: FSM state register ----
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err)                       state_nxt = RESP;
          else if (!bus.req_we)              state_nxt = RD;
          else if (bus.req_funct3 == 3'b010) state_nxt = WR;
          else                               state_nxt = RMW_RD;
        end
      end
      RD:      state_nxt = RESP;
      WR:      state_nxt = RESP;
      RMW_RD:  state_nxt = RMW_WR;
      RMW_WR:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory strobes decode straight from the state register (glitch-free);
  // the address is forced to zero outside an access.
  always_comb begin
    bus.MemRead    = (state == RD) || (state == RMW_RD);
    bus.MemWrite   = (state == WR) || (state == RMW_WR);
    mem_act        = bus.MemRead | bus.MemWrite;
    bus.add        = mem_act ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    bus.write_data = 32'h0;
    if (state == WR)     bus.write_data = wdata_q;
    if (state == RMW_WR) bus.write_data = lane_merge(rdata_q, f3_q, addr_q[1:0], wdata_q);
  end

  always_comb begin
    resp_now = 32'h0;
    if (!err_q && !we_q) resp_now = load_ext(rdata_q, f3_q, addr_q[1:0]);
  end

  // ---- stage boundary: response hold registers ----
  // Outputs show the live result during RESP and the last result afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_hold_q <= 32'h0;
      err_hold_q  <= 1'b0;
    end else if (state == RESP) begin
      resp_hold_q <= resp_now;
      err_hold_q  <= err_q;
    end
  end

  assign bus.resp_valid = (state == RESP);
  assign bus.resp_data  = (state == RESP) ? resp_now : resp_hold_q;
  assign bus.resp_err   = (state == RESP) ? err_q    : err_hold_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: self-checking bench for lsu_ctrl with a combinational
// word memory model, a vector table and a response scoreboard.
module tb_lsu_ctrl;
  localparam int ADDR_W = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mem_init = 1'b1;
  always #5 clk = ~clk;

  lsu_ctrl_if #(.ADDR_W(ADDR_W)) bus ();
  lsu_ctrl #(.ADDR_W(ADDR_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  // Data memory: combinational read, write takes effect at the clock edge.
  logic [31:0] mem [64];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[1] <= 32'h80F0_1234;
    end else if (bus.MemWrite) begin
      mem[bus.add[7:2]] <= bus.write_data;
    end
  end
  assign bus.read_data = bus.MemRead ? mem[bus.add[7:2]] : 32'h0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    logic [7:0]  wadd;
    logic [31:0] wdat;
  } exp_t;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [7:0]  addr;
    logic [31:0] wdata;
    exp_t        e;
  } vec_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor
  exp_t        sb[$];
  exp_t        mon_e;
  int          acc_cyc = 0;
  int          nrd = 0;
  int          nwr = 0;
  int          resp_cnt = 0;
  logic [7:0]  wadd;
  logic [31:0] wdat;

  always @(negedge clk) begin
    if (cyc > 0) begin
      if (bus.req_valid && bus.req_ready && !reset) begin
        acc_cyc = cyc;
        nrd = 0;
        nwr = 0;
      end
      if (bus.MemRead) nrd++;
      if (bus.MemWrite) begin
        nwr++;
        wadd = bus.add;
        wdat = bus.write_data;
      end
      chk("rd_wr_exclusive", {31'h0, bus.MemRead & bus.MemWrite}, 32'h0);
      if (!bus.MemWrite) chk("wdata_idle_zero", bus.write_data, 32'h0);
      if (bus.resp_valid) begin
        resp_cnt++;
        if (sb.size() == 0) begin
          chk("unexpected_resp", 32'h1, 32'h0);
        end else begin
          mon_e = sb.pop_front();
          chk("resp_data", bus.resp_data, mon_e.data);
          chk("resp_err", {31'h0, bus.resp_err}, {31'h0, mon_e.err});
          chk("latency", cyc - acc_cyc, mon_e.lat);
          chk("memread_cycles", nrd, mon_e.nrd);
          chk("memwrite_cycles", nwr, mon_e.nwr);
          if (mon_e.nwr > 0) begin
            chk("write_add", {24'h0, wadd}, {24'h0, mon_e.wadd});
            chk("write_data", wdat, mon_e.wdat);
          end
        end
      end
    end
  end

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [7:0] a,
                              input logic [31:0] wd, input logic [31:0] d, input logic er,
                              input int lat, input int r, input int w,
                              input logic [7:0] wa, input logic [31:0] wv);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd;
    v.e.data = d; v.e.err = er; v.e.lat = lat; v.e.nrd = r; v.e.nwr = w;
    v.e.wadd = wa; v.e.wdat = wv;
    return v;
  endfunction

  task automatic send(input logic we, input logic [2:0] f3, input logic [7:0] a,
                      input logic [31:0] wd);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (!bus.req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_wait", {31'h0, bus.req_ready}, 32'h1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("resp_timeout", sb.size(), 0);
    sb.delete();
  endtask

  vec_t vt[$];
  int   rc0;

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 8'h00;
    bus.req_wdata  = 32'h0;

    //            we    f3      addr   wdata          resp_data      err  lat rd wr wadd   wdat
    vt.push_back(mk(1'b0, 3'b000, 8'h07, 32'h0,        32'hFFFF_FF80, 1'b0, 2, 1, 0, 8'h00, 32'h0));
    vt.push_back(mk(1'b0, 3'b100, 8'h07, 32'h0,        32'h0000_0080, 1'b0, 2, 1, 0, 8'h00, 32'h0));
    vt.push_back(mk(1'b0, 3'b001, 8'h06, 32'h0,        32'hFFFF_80F0, 1'b0, 2, 1, 0, 8'h00, 32'h0));
    vt.push_back(mk(1'b0, 3'b101, 8'h04, 32'h0,        32'h0000_1234, 1'b0, 2, 1, 0, 8'h00, 32'h0));
    vt.push_back(mk(1'b0, 3'b010, 8'h04, 32'h0,        32'h80F0_1234, 1'b0, 2, 1, 0, 8'h00, 32'h0));
    vt.push_back(mk(1'b1, 3'b010, 8'h04, 32'h1122_3344, 32'h0,        1'b0, 2, 0, 1, 8'h04, 32'h1122_3344));
    vt.push_back(mk(1'b1, 3'b000, 8'h05, 32'h0000_00AB, 32'h0,        1'b0, 3, 1, 1, 8'h04, 32'h1122_AB44));
    vt.push_back(mk(1'b0, 3'b010, 8'h04, 32'h0,        32'h1122_AB44, 1'b0, 2, 1, 0, 8'h00, 32'h0));
    vt.push_back(mk(1'b1, 3'b010, 8'h08, 32'hDEAD_BEEF, 32'h0,        1'b0, 2, 0, 1, 8'h08, 32'hDEAD_BEEF));
    vt.push_back(mk(1'b0, 3'b010, 8'h08, 32'h0,        32'hDEAD_BEEF, 1'b0, 2, 1, 0, 8'h00, 32'h0));
`ifdef LSU_MISALIGN_TRAP_EN
    vt.push_back(mk(1'b0, 3'b010, 8'h0A, 32'h0,        32'h0,         1'b1, 1, 0, 0, 8'h00, 32'h0));
    vt.push_back(mk(1'b0, 3'b001, 8'h0B, 32'h0,        32'h0,         1'b1, 1, 0, 0, 8'h00, 32'h0));
`else
    vt.push_back(mk(1'b0, 3'b010, 8'h0A, 32'h0,        32'hDEAD_BEEF, 1'b0, 2, 1, 0, 8'h00, 32'h0));
    vt.push_back(mk(1'b0, 3'b001, 8'h0B, 32'h0,        32'hFFFF_DEAD, 1'b0, 2, 1, 0, 8'h00, 32'h0));
`endif
    vt.push_back(mk(1'b0, 3'b011, 8'h08, 32'h0,        32'h0,         1'b1, 1, 0, 0, 8'h00, 32'h0));
    vt.push_back(mk(1'b0, 3'b110, 8'h08, 32'h0,        32'h0,         1'b1, 1, 0, 0, 8'h00, 32'h0));
    vt.push_back(mk(1'b1, 3'b011, 8'h08, 32'h5555_5555, 32'h0,        1'b1, 1, 0, 0, 8'h00, 32'h0));
    vt.push_back(mk(1'b1, 3'b100, 8'h08, 32'h5555_5555, 32'h0,        1'b1, 1, 0, 0, 8'h00, 32'h0));
    vt.push_back(mk(1'b1, 3'b001, 8'h0A, 32'h1234_CAFE, 32'h0,        1'b0, 3, 1, 1, 8'h08, 32'hCAFE_BEEF));
    vt.push_back(mk(1'b0, 3'b101, 8'h0A, 32'h0,        32'h0000_CAFE, 1'b0, 2, 1, 0, 8'h00, 32'h0));
    vt.push_back(mk(1'b0, 3'b100, 8'h09, 32'h0,        32'h0000_00BE, 1'b0, 2, 1, 0, 8'h00, 32'h0));

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    mem_init = 1'b0;

    // Idle after reset: every output at its reset value
    repeat (3) begin
      @(negedge clk);
      chk("rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
      chk("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
      chk("rst_resp_data", bus.resp_data, 32'h0);
      chk("rst_resp_err", {31'h0, bus.resp_err}, 32'h0);
      chk("rst_memread", {31'h0, bus.MemRead}, 32'h0);
      chk("rst_memwrite", {31'h0, bus.MemWrite}, 32'h0);
      chk("rst_add", {24'h0, bus.add}, 32'h0);
    end

    foreach (vt[i]) begin
      sb.push_back(vt[i].e);
      send(vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata);
      wait_done();
    end

    // Response fields hold after the strobe
    @(negedge clk);
    chk("hold_valid_low", {31'h0, bus.resp_valid}, 32'h0);
    chk("hold_resp_data", bus.resp_data, 32'h0000_00BE);
    chk("hold_resp_err", {31'h0, bus.resp_err}, 32'h0);

    // Reset during the RMW_RD cycle of an SH: no write, no response
    rc0 = resp_cnt;
    @(posedge clk); #1;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b001;
    bus.req_addr   = 8'h06;
    bus.req_wdata  = 32'h0000_5555;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("abort_in_rmw_rd", {31'h0, bus.MemRead}, 32'h1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_ready", {31'h0, bus.req_ready}, 32'h1);
    repeat (4) @(negedge clk);
    chk("abort_no_write", nwr, 0);
    chk("abort_no_resp", resp_cnt, rc0);
    chk("abort_mem_kept", mem[1], 32'h1122_AB44);

    sb.push_back(mk(1'b0, 3'b010, 8'h04, 32'h0, 32'h1122_AB44, 1'b0, 2, 1, 0, 8'h00, 32'h0).e);
    send(1'b0, 3'b010, 8'h04, 32'h0);
    wait_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
